// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: FIFO-buffered register-command sequencer feeding the UART command/response engine.
// Optional per-command timeout is compiled in with `define UART_CMD_TIMEOUT_EN.
module uart_cmd_seq #(
  parameter int CMD_WIDTH  = 16,
  parameter int READ_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int TO_CYCLES  = 65535
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [CMD_WIDTH-1:0]     push_cmd,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [CMD_WIDTH-1:0]     cmd_out,
  output logic                     cmd_vld,
  input  logic                     cmd_rdy,
  input  logic                     read_rdy,
  input  logic [READ_WIDTH-1:0]    read_data,
  output logic                     rsp_vld,
  output logic [READ_WIDTH-1:0]    rsp_data,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   LVL_ZERO = (AW+1)'(1'b0);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  if ((DEPTH < 32'sd2) || ((DEPTH & (DEPTH - 32'sd1)) != 32'sd0) ||
      (TO_CYCLES < 32'sd1) || (TO_CYCLES > 32'sd1048575)) begin : g_param_check
    $error("uart_cmd_seq: DEPTH must be a power of two >= 2 and TO_CYCLES in 1..2^20-1");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_WAIT_RSP  = 3'd4,
    S_RSP       = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CMD_WIDTH-1:0]  r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_level;
  logic [AW:0]           w_level_nxt;
  logic                  r_full;
  logic                  r_ovf;
  logic [CMD_WIDTH-1:0]  r_cmd_out;
  logic                  r_cmd_vld;
  logic                  r_rsp_vld;
  logic [READ_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_err;
  logic                  r_busy;
  logic                  r_got;
  logic [READ_WIDTH-1:0] r_cap;
  logic                  w_push_ok;
  logic                  w_pop;
  logic                  w_xfer;
  logic                  w_waiting;
  logic                  w_to_hit;
  logic                  w_rsp_vld_nxt;
  logic [READ_WIDTH-1:0] w_rsp_data_nxt;
  logic                  w_rsp_err_nxt;

  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign w_push_ok = push & ~r_full;
  assign w_pop     = (r_state == S_IDLE) && (r_level != LVL_ZERO);
  assign w_xfer    = (r_state == S_ISSUE) && cmd_rdy;
  assign w_waiting = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE) ||
                     (r_state == S_WAIT_RSP);

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [19:0] TO_LAST = 20'(TO_CYCLES - 1);
  logic [19:0] r_to_cnt;

  // Per-command timeout counter, restarted on every transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= 20'd0;
    end else if (w_xfer) begin
      r_to_cnt <= 20'd0;
    end else if (w_waiting) begin
      r_to_cnt <= r_to_cnt + 20'd1;
    end
  end

  assign w_to_hit = w_waiting && (r_to_cnt >= TO_LAST);
`else
  assign w_to_hit = 1'b0;
`endif

  // FIFO occupancy next value.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push_ok, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_ONE;
      2'b01:   w_level_nxt = r_level - LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // FIFO storage (no reset needed: occupancy tracking guards every read).
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_cmd;
    end
  end

  // FIFO pointers, occupancy and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= LVL_ZERO;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_FULL);
      r_ovf   <= push & r_full;
    end
  end

  // Sequencer next state and the response that goes out with the move into RSP.
  always_comb begin
    w_state_nxt    = r_state;
    w_rsp_vld_nxt  = 1'b0;
    w_rsp_data_nxt = '0;
    w_rsp_err_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pop) w_state_nxt = S_ISSUE;
        else       w_state_nxt = S_IDLE;
      end
      S_ISSUE: begin
        if (cmd_rdy) w_state_nxt = S_WAIT_BUSY;
        else         w_state_nxt = S_ISSUE;
      end
      S_WAIT_BUSY: begin
        if (w_to_hit) begin
          w_state_nxt   = S_RSP;
          w_rsp_vld_nxt = 1'b1;
          w_rsp_err_nxt = 1'b1;
        end else if (!cmd_rdy) begin
          w_state_nxt = r_cmd_out[CMD_WIDTH-1] ? S_WAIT_DONE : S_WAIT_RSP;
        end else begin
          w_state_nxt = S_WAIT_BUSY;
        end
      end
      S_WAIT_DONE: begin
        if (cmd_rdy) begin
          w_state_nxt   = S_RSP;
          w_rsp_vld_nxt = 1'b1;
        end else if (w_to_hit) begin
          w_state_nxt   = S_RSP;
          w_rsp_vld_nxt = 1'b1;
          w_rsp_err_nxt = 1'b1;
        end else begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_RSP: begin
        // Data arriving on the completion cycle itself still counts as a good read.
        if (cmd_rdy) begin
          w_state_nxt   = S_RSP;
          w_rsp_vld_nxt = 1'b1;
          if (read_rdy) begin
            w_rsp_data_nxt = read_data;
          end else if (r_got) begin
            w_rsp_data_nxt = r_cap;
          end else begin
            w_rsp_err_nxt = 1'b1;
          end
        end else if (w_to_hit) begin
          w_state_nxt   = S_RSP;
          w_rsp_vld_nxt = 1'b1;
          w_rsp_err_nxt = 1'b1;
        end else begin
          w_state_nxt = S_WAIT_RSP;
        end
      end
      S_RSP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sequencer state, registered outputs and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cmd_out  <= '0;
      r_cmd_vld  <= 1'b0;
      r_busy     <= 1'b0;
      r_rsp_vld  <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_got      <= 1'b0;
      r_cap      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cmd_vld  <= (w_state_nxt == S_ISSUE);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_rsp_vld  <= w_rsp_vld_nxt;
      r_rsp_data <= w_rsp_data_nxt;
      r_rsp_err  <= w_rsp_err_nxt;
      if (w_pop) begin
        r_cmd_out <= r_mem[r_rd_ptr];
      end
      if (w_xfer) begin
        r_got <= 1'b0;
        r_cap <= '0;
      end else if ((r_state == S_WAIT_RSP) && read_rdy) begin
        r_got <= 1'b1;
        r_cap <= read_data;
      end
    end
  end

  assign full     = r_full;
  assign level    = r_level;
  assign ovf      = r_ovf;
  assign cmd_out  = r_cmd_out;
  assign cmd_vld  = r_cmd_vld;
  assign rsp_vld  = r_rsp_vld;
  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;
  assign busy     = r_busy;

endmodule
